// File: rtl/ne_pkg.sv
// ne_pkg: shared state type and default parameters for the neuron sequencer.
package ne_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE_DATA = 3'd1,
    ST_WRITE_THR  = 3'd2,
    ST_COMPUTE    = 3'd3,
    ST_WAIT_OUT   = 3'd4,
    ST_READ_OUT   = 3'd5
  } ne_seq_state_t;

  localparam int NE_DEPTH         = 64;
  localparam int NE_NUM_CH        = 4;
  localparam int NE_THRESH_CYCLES = 2;
  localparam int NE_PIPE_LAT      = 2;

endpackage

// File: rtl/ne_edge_pulse.sv
// ne_edge_pulse: registered one-cycle pulse on a rising edge of i_sig.
module ne_edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_sig_d;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
      r_pulse <= i_sig & ~r_sig_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/ne_seq_ctrl.sv
// ne_seq_ctrl: per-neuron write/threshold/compute/read sequencer.
// Optional busy-cycle counter enabled by NE_SEQ_PERF_CNT_EN.
module ne_seq_ctrl
  import ne_pkg::*;
#(
  parameter int DEPTH         = NE_DEPTH,
  parameter int NUM_CH        = NE_NUM_CH,
  parameter int THRESH_CYCLES = NE_THRESH_CYCLES,
  parameter int PIPE_LAT      = NE_PIPE_LAT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chip_sel,
  input  logic             wr_en,
  input  logic             rd_ack,
  output logic             rst_mem,
  output logic             mul_mem_en,
  output logic             ac_mem_en,
  output logic             threshold_ready,
  output logic             output_ready,
  output logic [PTR_W-1:0] wr_data_ptr,
  output logic [PTR_W-1:0] rd_data_ptr,
  output logic [CH_W-1:0]  ch_idx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      perf_cycles
);

  localparam logic [PTR_W-1:0] LP_PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]  LP_CH_MAX  = CH_W'(NUM_CH - 1);
  localparam logic [2:0]       LP_THR_MAX = 3'(THRESH_CYCLES - 1);
  localparam logic [3:0]       LP_DLY_MAX = 4'(PIPE_LAT - 1);

  ne_seq_state_t    r_state, w_state_nxt;
  logic [PTR_W-1:0] r_wptr, w_wptr_nxt;
  logic [PTR_W-1:0] r_rptr, w_rptr_nxt;
  logic [2:0]       r_tcnt, w_tcnt_nxt;
  logic [3:0]       r_dcnt, w_dcnt_nxt;
  logic [CH_W-1:0]  r_ch, w_ch_nxt;
  logic             r_done, w_done_nxt;
  logic             w_rst_mem;

  ne_edge_pulse u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_sig   (chip_sel),
    .o_pulse (w_rst_mem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_tcnt  <= '0;
      r_dcnt  <= '0;
      r_ch    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_ch    <= w_ch_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_tcnt_nxt  = r_tcnt;
    w_dcnt_nxt  = r_dcnt;
    w_ch_nxt    = r_ch;
    w_done_nxt  = 1'b0;
    // deselect beats every other transition and wipes the session
    if (!chip_sel) begin
      w_state_nxt = ST_IDLE;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_tcnt_nxt  = '0;
      w_dcnt_nxt  = '0;
      w_ch_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wr_en) w_state_nxt = ST_WRITE_DATA;
        end
        ST_WRITE_DATA: begin
          if (wr_en) begin
            if (r_wptr == LP_PTR_MAX) begin
              w_wptr_nxt  = '0;
              w_state_nxt = ST_WRITE_THR;
            end else begin
              w_wptr_nxt = r_wptr + PTR_W'(1);
            end
          end
        end
        ST_WRITE_THR: begin
          if (wr_en) begin
            if (r_tcnt == LP_THR_MAX) begin
              w_tcnt_nxt  = '0;
              w_state_nxt = ST_COMPUTE;
            end else begin
              w_tcnt_nxt = r_tcnt + 3'd1;
            end
          end
        end
        ST_COMPUTE: begin
          if (r_rptr == LP_PTR_MAX) begin
            w_rptr_nxt  = '0;
            w_dcnt_nxt  = '0;
            w_state_nxt = ST_WAIT_OUT;
          end else begin
            w_rptr_nxt = r_rptr + PTR_W'(1);
          end
        end
        ST_WAIT_OUT: begin
          if (r_dcnt == LP_DLY_MAX) begin
            w_dcnt_nxt  = '0;
            w_state_nxt = ST_READ_OUT;
          end else begin
            w_dcnt_nxt = r_dcnt + 4'd1;
          end
        end
        ST_READ_OUT: begin
          if (rd_ack) begin
            if (r_ch == LP_CH_MAX) begin
              w_ch_nxt    = '0;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_ch_nxt    = r_ch + CH_W'(1);
              w_state_nxt = ST_WRITE_DATA;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rst_mem         = w_rst_mem;
  assign mul_mem_en      = (r_state == ST_COMPUTE);
  assign ac_mem_en       = (r_state == ST_COMPUTE);
  assign threshold_ready = (r_state == ST_WRITE_THR) & wr_en;
  assign output_ready    = (r_state == ST_READ_OUT);
  assign wr_data_ptr     = r_wptr;
  assign rd_data_ptr     = r_rptr;
  assign ch_idx          = r_ch;
  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;

`ifdef NE_SEQ_PERF_CNT_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (w_rst_mem) begin
      r_perf <= '0;
    end else if (busy && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_ne_seq_ctrl.sv
// tb_ne_seq_ctrl: directed scenarios plus random traffic vs a phase model.
module tb_ne_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int NCH   = 2;
  localparam int TCY   = 2;
  localparam int PLAT  = 2;

  localparam int PH_IDLE = 0;
  localparam int PH_WD   = 1;
  localparam int PH_THR  = 2;
  localparam int PH_CMP  = 3;
  localparam int PH_WAIT = 4;
  localparam int PH_RD   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chip_sel = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_ack = 1'b0;
  logic        rst_mem, mul_mem_en, ac_mem_en;
  logic        threshold_ready, output_ready;
  logic [1:0]  wr_data_ptr, rd_data_ptr;
  logic [0:0]  ch_idx;
  logic        busy, done;
  logic [15:0] perf_cycles;

  ne_seq_ctrl #(
    .DEPTH(DEPTH), .NUM_CH(NCH), .THRESH_CYCLES(TCY), .PIPE_LAT(PLAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chip_sel(chip_sel), .wr_en(wr_en),
    .rd_ack(rd_ack), .rst_mem(rst_mem), .mul_mem_en(mul_mem_en),
    .ac_mem_en(ac_mem_en), .threshold_ready(threshold_ready),
    .output_ready(output_ready), .wr_data_ptr(wr_data_ptr),
    .rd_data_ptr(rd_data_ptr), .ch_idx(ch_idx), .busy(busy),
    .done(done), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // phase-level reference: phase, how far into it, and session bookkeeping
  int m_ph, m_wp, m_rp, m_tc, m_dc, m_ch;
  int m_done, m_rm, m_csd, m_perf;
  int n_rm, n_done, n_thr, n_en, n_rdy;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_wp = 0; m_rp = 0; m_tc = 0; m_dc = 0; m_ch = 0;
    m_done = 0; m_rm = 0; m_csd = 0; m_perf = 0;
  endtask

  task automatic model_step(input bit cs, input bit we, input bit ack);
`ifdef NE_SEQ_PERF_CNT_EN
    if (m_rm != 0) m_perf = 0;
    else if (m_ph != PH_IDLE && m_perf < 65535) m_perf++;
`endif
    m_rm = (cs && !m_csd) ? 1 : 0;
    m_csd = cs ? 1 : 0;
    m_done = 0;
    if (!cs) begin
      m_ph = PH_IDLE; m_wp = 0; m_rp = 0; m_tc = 0; m_dc = 0; m_ch = 0;
    end else if (m_ph == PH_IDLE) begin
      if (we) m_ph = PH_WD;
    end else if (m_ph == PH_WD) begin
      if (we) begin
        m_wp = (m_wp + 1) % DEPTH;
        if (m_wp == 0) m_ph = PH_THR;
      end
    end else if (m_ph == PH_THR) begin
      if (we) begin
        m_tc = (m_tc + 1) % TCY;
        if (m_tc == 0) m_ph = PH_CMP;
      end
    end else if (m_ph == PH_CMP) begin
      m_rp = (m_rp + 1) % DEPTH;
      if (m_rp == 0) begin m_ph = PH_WAIT; m_dc = 0; end
    end else if (m_ph == PH_WAIT) begin
      m_dc++;
      if (m_dc == PLAT) begin m_dc = 0; m_ph = PH_RD; end
    end else if (ack) begin
      if (m_ch == NCH - 1) begin
        m_ch = 0; m_done = 1; m_ph = PH_IDLE;
      end else begin
        m_ch++; m_ph = PH_WD;
      end
    end
  endtask

  task automatic check_all();
    chk("rst_mem", int'(rst_mem), m_rm);
    chk("mul_mem_en", int'(mul_mem_en), int'(m_ph == PH_CMP));
    chk("ac_mem_en", int'(ac_mem_en), int'(m_ph == PH_CMP));
    chk("output_ready", int'(output_ready), int'(m_ph == PH_RD));
    chk("wr_data_ptr", int'(wr_data_ptr), m_wp);
    chk("rd_data_ptr", int'(rd_data_ptr), m_rp);
    chk("ch_idx", int'(ch_idx), m_ch);
    chk("busy", int'(busy), int'(m_ph != PH_IDLE));
    chk("done", int'(done), m_done);
    chk("perf_cycles", int'(perf_cycles), m_perf);
  endtask

  task automatic cyc(input bit cs, input bit we, input bit ack);
    chip_sel = cs; wr_en = we; rd_ack = ack;
    #1;
    chk("threshold_ready", int'(threshold_ready),
        int'(m_ph == PH_THR && we));
    if (threshold_ready) n_thr++;
    @(posedge clk);
    model_step(cs, we, ack);
    #1;
    check_all();
    n_rm   += int'(rst_mem);
    n_done += int'(done);
    n_en   += int'(mul_mem_en);
    n_rdy  += int'(output_ready);
  endtask

  task automatic run_to(input int ph, input bit we);
    int k = 0;
    while (m_ph != ph && k < 100) begin
      cyc(1'b1, we, 1'b0);
      k++;
    end
    n_chk++;
    assert (m_ph == ph) else begin
      n_fail++;
      $error("FAIL timeout waiting for phase %0d observed=%0d", ph, m_ph);
    end
  endtask

  task automatic clr_counts();
    n_rm = 0; n_done = 0; n_thr = 0; n_en = 0; n_rdy = 0;
  endtask

  initial begin
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("thr_rdy_reset", int'(threshold_ready), 0);
    rst_n = 1'b1;

    // nominal two-channel session
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run_to(PH_RD, 1'b1);
    chk("nom_rst_mem_pulses", n_rm, 1);
    chk("nom_thr_cycles", n_thr, TCY);
    chk("nom_en_cycles", n_en, DEPTH);
    cyc(1'b1, 1'b0, 1'b1);
    chk("ch_after_ack0", int'(ch_idx), 1);
    run_to(PH_RD, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("done_pulse", int'(done), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("done_once", n_done, 1);
    chk("idle_busy", int'(busy), 0);

    // write pause at pointer 2, then abort mid-compute
    clr_counts();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("pause_ptr", int'(wr_data_ptr), 2);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("pause_hold", int'(wr_data_ptr), 2);
    cyc(1'b1, 1'b1, 1'b0);
    chk("resume_ptr", int'(wr_data_ptr), 3);
    run_to(PH_CMP, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_at_rp", int'(rd_data_ptr), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_busy", int'(busy), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_rst_mem", int'(rst_mem), 1);
    chk("abort_no_done", n_done, 0);

    // async reset during output wait
    cyc(1'b1, 1'b1, 1'b0);
    run_to(PH_WAIT, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("rel_rst_mem", int'(rst_mem), 1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom % 40) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
